// File: rtl/prod_ctrl_fsm.sv
// prod_ctrl_fsm: producer-control state machine. Arbitrates NUM_CH producers
// onto one shared buffer. It edge-detects the button inputs, pauses production
// on a full buffer with hysteresis, drains the buffer on stop, can abort a
// stuck wait on timeout, and latches the slow-clock program code.
module prod_ctrl_fsm #(
    parameter int NUM_CH       = 2,
    parameter int CNT_W        = 4,
    parameter int RESUME_LEVEL = 4,
    parameter int WAIT_TIMEOUT = 0,
    parameter int TO_W         = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         start,
    input  logic                      stop,
    input  logic                      update,
    input  logic [2:0]                prog,
    input  logic                      buf_full,
    input  logic                      buf_empty,
    input  logic [CNT_W-1:0]          buf_count,
    input  logic                      out_valid,
    output logic [NUM_CH-1:0]         ch_en,
    output logic [$clog2(NUM_CH)-1:0] ch_sel,
    output logic [3:0]                led,
    output logic [2:0]                prog_out,
    output logic                      prog_load,
    output logic                      timeout
);

    localparam int SEL_W = $clog2(NUM_CH);

    // One-hot state encoding doubles as the led pattern.
    localparam logic [3:0] S_IDLE  = 4'b0001;
    localparam logic [3:0] S_COMM  = 4'b0010;
    localparam logic [3:0] S_WAIT  = 4'b0100;
    localparam logic [3:0] S_DRAIN = 4'b1000;

    localparam bit              TO_EN      = (WAIT_TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(WAIT_TIMEOUT - 1);
    // A resume level beyond the count range means the level test always passes.
    localparam bit              RESUME_ANY = (RESUME_LEVEL >= (2 ** CNT_W));
    localparam logic [CNT_W-1:0] RESUME_LVL = CNT_W'(RESUME_LEVEL);

    // Lowest set index of a request vector (lowest channel wins).
    function automatic logic [SEL_W-1:0] lowest_idx(input logic [NUM_CH-1:0] v);
        logic [SEL_W-1:0] idx;
        idx = {SEL_W{1'b0}};
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = v[i] ? SEL_W'(i) : idx;
        end
        return idx;
    endfunction

    // One-hot decode of a channel index.
    function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] oh;
        for (int i = 0; i < NUM_CH; i++) begin
            oh[i] = (SEL_W'(i) == sel);
        end
        return oh;
    endfunction

    logic [NUM_CH-1:0] start_q, start_qq, start_p;
    logic              stop_q, stop_qq, stop_p;
    logic              upd_q, upd_qq, upd_p;

    logic [3:0]        state_q, state_d;
    logic [SEL_W-1:0]  ch_sel_q, ch_sel_d;
    logic [NUM_CH-1:0] ch_en_q, ch_en_d;
    logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [2:0]        prog_out_q, prog_out_d;
    logic              prog_load_q, prog_load_d;
    logic              timeout_q, timeout_d;
    logic              to_fire_s;
    logic              to_hit_s;
    logic              resume_ok_s;

    // Two-stage button sampling; a rising edge gives a single one-cycle pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            start_q  <= {NUM_CH{1'b0}};
            start_qq <= {NUM_CH{1'b0}};
            stop_q   <= 1'b0;
            stop_qq  <= 1'b0;
            upd_q    <= 1'b0;
            upd_qq   <= 1'b0;
        end else begin
            start_q  <= start;
            start_qq <= start_q;
            stop_q   <= stop;
            stop_qq  <= stop_q;
            upd_q    <= update;
            upd_qq   <= upd_q;
        end
    end

    assign start_p     = start_q & ~start_qq;
    assign stop_p      = stop_q & ~stop_qq;
    assign upd_p       = upd_q & ~upd_qq;
    assign to_hit_s    = TO_EN && (wait_cnt_q == TO_LAST);
    assign resume_ok_s = !buf_full && (RESUME_ANY || (buf_count <= RESUME_LVL));

    // State register plus all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ch_sel_q    <= {SEL_W{1'b0}};
            ch_en_q     <= {NUM_CH{1'b0}};
            wait_cnt_q  <= {TO_W{1'b0}};
            prog_out_q  <= 3'd0;
            prog_load_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_sel_q    <= ch_sel_d;
            ch_en_q     <= ch_en_d;
            wait_cnt_q  <= wait_cnt_d;
            prog_out_q  <= prog_out_d;
            prog_load_q <= prog_load_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state logic; stop outranks full and timeout, timeout outranks resume.
    always_comb begin
        state_d   = state_q;
        ch_sel_d  = ch_sel_q;
        to_fire_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|start_p) begin
                    state_d  = S_COMM;
                    ch_sel_d = lowest_idx(start_p);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COMM: begin
                if (stop_p) begin
                    state_d = S_DRAIN;
                end else if (buf_full) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_COMM;
                end
            end
            S_WAIT: begin
                if (stop_p) begin
                    state_d = S_DRAIN;
                end else if (to_hit_s) begin
                    state_d   = S_DRAIN;
                    to_fire_s = 1'b1;
                end else if (resume_ok_s) begin
                    state_d = S_COMM;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DRAIN: begin
                if (buf_empty && !out_valid) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                // Any corrupted encoding falls back to a safe idle.
                state_d  = S_IDLE;
                ch_sel_d = {SEL_W{1'b0}};
            end
        endcase
    end

    // Output / datapath next values derived from the chosen transition.
    always_comb begin
        ch_en_d     = {NUM_CH{1'b0}};
        wait_cnt_d  = {TO_W{1'b0}};
        prog_out_d  = prog_out_q;
        prog_load_d = upd_p;
        timeout_d   = to_fire_s;
        if (state_d == S_COMM) begin
            ch_en_d = onehot(ch_sel_d);
        end else begin
            ch_en_d = {NUM_CH{1'b0}};
        end
        if ((state_q == S_WAIT) && (state_d == S_WAIT)) begin
            if (wait_cnt_q == {TO_W{1'b1}}) begin
                wait_cnt_d = wait_cnt_q;
            end else begin
                wait_cnt_d = wait_cnt_q + TO_W'(1);
            end
        end else begin
            wait_cnt_d = {TO_W{1'b0}};
        end
        if (upd_p) begin
            prog_out_d = prog;
        end else begin
            prog_out_d = prog_out_q;
        end
    end

    assign led       = state_q;
    assign ch_en     = ch_en_q;
    assign ch_sel    = ch_sel_q;
    assign prog_out  = prog_out_q;
    assign prog_load = prog_load_q;
    assign timeout   = timeout_q;

endmodule
